// File: rtl/exe_lsu_req.sv
// exe_lsu_req -- load/store request unit at the EXE->MEM boundary.
//
// Accepts one memory op per in_valid/in_ready handshake and drives an
// SRAM-like split bus (req/addr_ok for the address phase, data_ok for
// in-order completion). Up to OUTSTANDING accepted ops are tracked in a
// circular in-order queue. Load data is lane-aligned and sign/zero
// extended before it is presented to MEM. Misaligned ops optionally
// complete immediately as alignment exceptions (ALE) without touching
// the bus. flush cancels every accepted op that has not yet been
// returned; cancelled ops still drain their bus traffic silently.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   in_valid/in_ready      op handshake from EXE
//   in_wr, in_size,        op kind (store/load), size (2^size bytes),
//   in_unsigned            zero-extend loads
//   in_addr, in_wdata,     byte address, LSB-justified store data,
//   in_tag                 opaque tag returned with the response
//   flush                  cancel all accepted, unreturned ops
//   req, wr, size, wstrb,  bus address phase (held until addr_ok)
//   addr, wdata, addr_ok
//   rdata, data_ok         bus completion of oldest issued op
//   out_valid/out_ready    response handshake to MEM
//   out_rdata, out_tag,    extended load data (0 for stores/ALE), tag,
//   out_ale                alignment-exception flag
module exe_lsu_req #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 2,
  parameter int TAG_W       = 5,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_wr,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                data_ok,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_ale
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  // Per-entry payload; the control bits (done/cancelled/issued) live in
  // separate vectors so flush can set all cancel bits in one step.
  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic              uns;
    logic [OFF_W-1:0]  lo;
    logic [TAG_W-1:0]  tag;
    logic              ale;
    logic [DATA_W-1:0] rdata;
  } ent_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a;
    endcase
  endfunction

  function automatic logic [BYTES-1:0] strobes(input logic [OFF_W-1:0] lo,
                                               input logic [1:0] sz);
    logic [BYTES-1:0] s;
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < BYTES; i++)
      s[i] = (i >= int'(lo)) && (i < int'(lo) + nb);
    return s;
  endfunction

  // Low 2^size bytes of the store data copied into every lane.
  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] sz);
    logic [DATA_W-1:0] r;
    int nb;
    nb = 1 << sz;
    if (nb > BYTES) nb = BYTES;
    for (int i = 0; i < BYTES; i++)
      r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  // Shift the addressed lane down and sign/zero extend from 8<<size bits.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [OFF_W-1:0] lo,
                                               input logic [1:0] sz,
                                               input logic uns);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] r;
    logic msb;
    int nbits;
    s = d >> {lo, 3'b000};
    nbits = 8 << sz;
    if (nbits > DATA_W) nbits = DATA_W;
    msb = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i == nbits - 1) msb = s[i];
    for (int i = 0; i < DATA_W; i++)
      r[i] = (i < nbits) ? s[i] : (msb & ~uns);
    return r;
  endfunction

  state_t                  state;
  ent_t                    ent   [OUTSTANDING];
  ent_t                    n_ent [OUTSTANDING];
  logic [OUTSTANDING-1:0]  e_done, e_canc, e_iss;
  logic [OUTSTANDING-1:0]  n_done, n_canc, n_iss;
  logic [PTR_W-1:0]        head, tail, req_idx;
  logic [PTR_W-1:0]        n_head, n_tail;
  logic [CNT_W-1:0]        cnt, n_cnt;
  logic [PTR_W-1:0]        dok_idx, sidx;
  logic                    dok_hit;
  logic                    silent, pop, push, full, mis;
  logic                    n_out_valid;
  ent_t                    hd;

  // Handshake decode. A silent pop retires a completed, cancelled head.
  always_comb begin
    silent   = (cnt != '0) && e_done[head] && e_canc[head];
    pop      = (out_valid && out_ready) || silent;
    full     = (cnt == CNT_W'(OUTSTANDING));
    in_ready = (state == S_IDLE) && !flush && (!full || pop);
    push     = in_valid && in_ready;
    mis      = (ALIGN_CHECK != 0) && misaligned(in_addr[2:0], in_size);
  end

  // data_ok always belongs to the oldest entry that has been issued on the
  // bus and not completed; ALE entries are never issued so they are skipped.
  always_comb begin
    dok_hit = 1'b0;
    dok_idx = '0;
    sidx    = '0;
    for (int k = 0; k < OUTSTANDING; k++) begin
      sidx = PTR_W'((int'(head) + k) % OUTSTANDING);
      if (!dok_hit && (k < int'(cnt)) && e_iss[sidx] && !e_done[sidx]) begin
        dok_hit = 1'b1;
        dok_idx = sidx;
      end
    end
  end

  // Next queue state; the response registers are loaded from the head of
  // this next state so out_* always mirror the head entry.
  always_comb begin
    n_head = pop  ? ptr_inc(head) : head;
    n_tail = push ? ptr_inc(tail) : tail;
    n_cnt  = cnt + CNT_W'(push) - CNT_W'(pop);
    n_done = e_done;
    n_canc = flush ? '1 : e_canc;
    n_iss  = e_iss;
    n_ent  = ent;
    if (data_ok && dok_hit) begin
      n_done[dok_idx]       = 1'b1;
      n_ent[dok_idx].rdata  = rdata;
    end
    if ((state == S_REQ) && addr_ok)
      n_iss[req_idx] = 1'b1;
    if (push) begin
      n_done[tail]      = mis;
      n_canc[tail]      = 1'b0;
      n_iss[tail]       = 1'b0;
      n_ent[tail].wr    = in_wr;
      n_ent[tail].size  = in_size;
      n_ent[tail].uns   = in_unsigned;
      n_ent[tail].lo    = in_addr[OFF_W-1:0];
      n_ent[tail].tag   = in_tag;
      n_ent[tail].ale   = mis;
      n_ent[tail].rdata = '0;
    end
    hd          = n_ent[n_head];
    n_out_valid = (n_cnt != '0) && n_done[n_head] && !n_canc[n_head];
  end

  // Stage boundary: queue control, request FSM with its bus outputs, and
  // the registered response port.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      req       <= 1'b0;
      wr        <= 1'b0;
      size      <= '0;
      wstrb     <= '0;
      addr      <= '0;
      wdata     <= '0;
      req_idx   <= '0;
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      e_done    <= '0;
      e_canc    <= '0;
      e_iss     <= '0;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_tag   <= '0;
      out_ale   <= 1'b0;
    end else begin
      head      <= n_head;
      tail      <= n_tail;
      cnt       <= n_cnt;
      e_done    <= n_done;
      e_canc    <= n_canc;
      e_iss     <= n_iss;
      out_valid <= n_out_valid;
      out_tag   <= n_out_valid ? hd.tag : '0;
      out_ale   <= n_out_valid && hd.ale;
      out_rdata <= (n_out_valid && !hd.ale && !hd.wr)
                   ? extend(hd.rdata, hd.lo, hd.size, hd.uns) : '0;
      case (state)
        S_IDLE: begin
          if (push && !mis) begin
            state   <= S_REQ;
            req     <= 1'b1;
            wr      <= in_wr;
            size    <= in_size;
            addr    <= in_addr;
            wstrb   <= in_wr ? strobes(in_addr[OFF_W-1:0], in_size) : '0;
            wdata   <= replicate(in_wdata, in_size);
            req_idx <= tail;
          end
        end
        S_REQ: begin
          if (addr_ok) begin
            state <= S_IDLE;
            req   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  // Stage boundary: entry payload storage, only meaningful while occupied.
  always_ff @(posedge clk) begin
    ent <= n_ent;
  end

endmodule
